// File: rtl/bytecomp_pkg.sv
// Shared definitions for the byte-comparator BIST: FSM states, default
// operand width and the mask that makes odd phase-1 vectors unequal.
package bytecomp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int ODD_MASK      = 1;

endpackage

// File: rtl/bytecomp_vecgen.sv
// Pure combinational mapping from (phase, index) to the stimulus vector and
// the comparator result a healthy comparator must return for it.
module bytecomp_vecgen
  import bytecomp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             phase_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             en_o,
  output logic             exp_o
);

  always_comb begin
    a_o   = k_i;
    en_o  = phase_i;
    // Phase 1 alternates equal / off-by-LSB operands to exercise both results.
    b_o   = (phase_i && k_i[0]) ? (k_i ^ WIDTH'(ODD_MASK)) : k_i;
    exp_o = en_o && (a_o == b_o);
  end

endmodule

// File: rtl/bytecomp_bist.sv
// BIST controller for an external combinational equality comparator: drives
// two phases of vectors, samples the result, counts and records mismatches.
module bytecomp_bist
  import bytecomp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_VEC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             en,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_en
);

  localparam logic [WIDTH-1:0] K_LAST = WIDTH'(N_VEC - 1);

  state_e           state_q;
  logic             phase_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             en_q, exp_q;
  logic             busy_q, done_q, pass_q;
  logic [7:0]       err_q;
  logic [WIDTH-1:0] fail_a_q, fail_b_q;
  logic             fail_en_q;

  logic             gen_phase_d;
  logic [WIDTH-1:0] gen_k_d;
  logic [WIDTH-1:0] gen_a, gen_b;
  logic             gen_en, gen_exp;
  logic             last_vec;
  logic             mismatch;
  logic [7:0]       err_d;

  bytecomp_vecgen #(.WIDTH(WIDTH)) u_vecgen (
    .phase_i (gen_phase_d),
    .k_i     (gen_k_d),
    .a_o     (gen_a),
    .b_o     (gen_b),
    .en_o    (gen_en),
    .exp_o   (gen_exp)
  );

  // Index of the vector to load on the next entry to DRIVE.
  always_comb begin
    last_vec    = phase_q && (k_q == K_LAST);
    gen_phase_d = phase_q;
    gen_k_d     = k_q + WIDTH'(1);
    if (state_q == IDLE) begin
      gen_phase_d = 1'b0;
      gen_k_d     = '0;
    end else if (k_q == K_LAST) begin
      gen_phase_d = 1'b1;
      gen_k_d     = '0;
    end
    mismatch = (state_q == CHECK) && (f != exp_q);
    err_d    = err_q;
    if (mismatch && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      en_q      <= 1'b0;
      exp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
      fail_en_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= DRIVE;
            busy_q    <= 1'b1;
            err_q     <= '0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            fail_en_q <= 1'b0;
            phase_q   <= gen_phase_d;
            k_q       <= gen_k_d;
            a_q       <= gen_a;
            b_q       <= gen_b;
            en_q      <= gen_en;
            exp_q     <= gen_exp;
          end
        end
        DRIVE: state_q <= CHECK;
        CHECK: begin
          err_q <= err_d;
          // A zero count means no earlier mismatch, so this one is the first.
          if (mismatch && (err_q == 8'd0)) begin
            fail_a_q  <= a_q;
            fail_b_q  <= b_q;
            fail_en_q <= en_q;
          end
          if (last_vec) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
            a_q     <= '0;
            b_q     <= '0;
            en_q    <= 1'b0;
            exp_q   <= 1'b0;
          end else begin
            state_q <= DRIVE;
            phase_q <= gen_phase_d;
            k_q     <= gen_k_d;
            a_q     <= gen_a;
            b_q     <= gen_b;
            en_q    <= gen_en;
            exp_q   <= gen_exp;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_en   = fail_en_q;

endmodule

// File: doc/bytecomp_bist.md
BYTECOMP_BIST -- requirements
Module: bytecomp_bist

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width driven to the comparator under test.
REQ-002 Parameter N_VEC, default 16, is the vectors per phase; range 2..2**WIDTH.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port start  input  1  requests one test run; sampled only in IDLE.
REQ-006 Port a  output  WIDTH  is operand A to the comparator under test.
REQ-007 Port b  output  WIDTH  is operand B to the comparator under test.
REQ-008 Port en  output  1  is the comparator enable.
REQ-009 Port f  input  1  is the comparator result; combinational from a, b, en.
REQ-010 Port busy  output  1  is high while a run is in progress.
REQ-011 Port done  output  1  is a one-cycle pulse at run end.
REQ-012 Port pass  output  1  is high when the last completed run had zero errors.
REQ-013 Port err_count  output  8  is the mismatch count, saturating at 255.
REQ-014 Ports fail_a / fail_b / fail_en  output  WIDTH / WIDTH / 1  hold the first failing vector of the run.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, CHECK and DONE.
REQ-016 Transitions SHALL be: IDLE->DRIVE on start; DRIVE->CHECK always; CHECK->DRIVE if vectors remain, else CHECK->DONE; DONE->IDLE always.
REQ-017 Each vector SHALL take 2 cycles: a/b/en registered on entry to DRIVE, f sampled at the CHECK->next edge.
REQ-018 Phase 0 (k = 0..N_VEC-1) SHALL drive en=0, a=k, b=k, expected f=0.
REQ-019 Phase 1 (k = 0..N_VEC-1) SHALL drive en=1, a=k, and b=k for even k or b=k^1 for odd k.
REQ-020 Expected f in phase 1 SHALL be en & (a==b).
REQ-021 Vector index arithmetic SHALL be modulo 2**WIDTH; the index counter SHALL NOT wrap within a phase.
REQ-022 On a mismatch err_count SHALL increment, saturating at 255 (no wrap).
REQ-023 On the first mismatch of a run, fail_a, fail_b and fail_en SHALL capture the driven vector; later mismatches SHALL NOT overwrite them.
REQ-024 Latency: with start accepted at edge E0, done SHALL be high during the cycle after edge E(4*N_VEC), which is 64 cycles for N_VEC=16.
REQ-025 busy SHALL be high from the cycle after start is accepted through the last CHECK cycle, and low in DONE and IDLE.
REQ-026 pass SHALL update on entry to DONE (err_count==0) and hold until the next DONE.
REQ-027 At start acceptance, err_count and the fail_* ports SHALL clear to 0.
REQ-028 start asserted while busy or in DONE SHALL be ignored, with no queuing.
REQ-029 In IDLE and DONE, a, b and en SHALL be 0.

Reset
REQ-030 When rst_n=0 at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL go to 0 the next cycle.
REQ-031 Reset mid-run SHALL abort the run with no done pulse; pass, err_count and fail_* SHALL be 0 afterwards.
REQ-032 Reset SHALL dominate a simultaneous start.

Structure
REQ-033 Package bytecomp_pkg SHALL hold the FSM state enum, the default WIDTH and the odd-vector mask constant (1).
REQ-034 Sub-module bytecomp_vecgen SHALL be combinational, mapping (phase, k) to (a, b, en, expected f).

Verification
REQ-035 Scenario ideal comparator model (f = en & (a==b)): start pulse -> done exactly 64 cycles later; pass=1; err_count=0.
REQ-036 Scenario f stuck at 1 -> err_count=24; fail_a=0, fail_b=0, fail_en=0; pass=0.
REQ-037 Scenario f stuck at 0 -> err_count=8; fail_a=0, fail_b=0, fail_en=1; pass=0.
REQ-038 Scenario model that ignores en (f = a==b) -> err_count=16; fail_en=0; pass=0.
REQ-039 Scenario rst_n=0 for 1 cycle at cycle 10 of a run -> next cycle busy=0, a=b=0, en=0; no done pulse; a following start completes with pass=1.
REQ-040 Scenario start re-pulsed at cycles 5 and 30 of a run -> exactly one done pulse; timing unchanged from REQ-024.
